// File: rtl/state_machine.sv
// Control FSM for a loop-based PUF array.
// Sweeps every loop REPETITIONS times: preset, evaluate, store.
module state_machine #(
  parameter int NUM_LOOPS        = 4,
  parameter int REPETITIONS_BITS = 16,
  parameter int REPETITIONS      = 2,
  parameter int EVAL_TIME_BITS   = 16,
  parameter int EVAL_TIME        = 8,
  parameter int CHALLENGE_BITS   = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [CHALLENGE_BITS-1:0]        challenge,
  output logic                             done,
  output logic                             reset_puf,
  output logic [$clog2(NUM_LOOPS-1):0]     select_puf,
  output logic                             enable_puf,
  output logic                             store_response_puf
);

  localparam int SELW   = $clog2(NUM_LOOPS-1) + 1;
  localparam int REP_T  = (REPETITIONS == 0) ? 1 : REPETITIONS;
  localparam int EVAL_T = (EVAL_TIME == 0) ? 1 : EVAL_TIME;

  localparam logic [SELW-1:0] LOOP_LAST =
    SELW'(NUM_LOOPS - 1);
  localparam logic [REPETITIONS_BITS-1:0] REP_LAST =
    REPETITIONS_BITS'(REP_T - 1);
  localparam logic [EVAL_TIME_BITS-1:0] EVAL_LAST =
    EVAL_TIME_BITS'(EVAL_T - 1);
  localparam logic [SELW:0] NL_W = (SELW+1)'(NUM_LOOPS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESET,
    S_EVAL,
    S_STORE,
    S_DONE
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nx;
  logic [CHALLENGE_BITS-1:0]   r_chal;
  logic [CHALLENGE_BITS-1:0]   w_chal_nx;
  logic [SELW-1:0]             r_loop;
  logic [SELW-1:0]             w_loop_nx;
  logic [REPETITIONS_BITS-1:0] r_rep;
  logic [REPETITIONS_BITS-1:0] w_rep_nx;
  logic [EVAL_TIME_BITS-1:0]   r_eval;
  logic [EVAL_TIME_BITS-1:0]   w_eval_nx;
  logic [SELW-1:0]             r_sel;
  logic [SELW-1:0]             w_sel_nx;
  logic [SELW-1:0]             w_start_idx;
  logic [SELW:0]               w_sum;
  logic                        r_done;
  logic                        r_rst;
  logic                        r_en;
  logic                        r_st;

  // First loop addressed is challenge mod NUM_LOOPS
  assign w_start_idx =
    SELW'(32'(w_chal_nx) % 32'(NUM_LOOPS));

  always_comb begin
    w_state_nx = r_state;
    w_chal_nx  = r_chal;
    w_loop_nx  = r_loop;
    w_rep_nx   = r_rep;
    w_eval_nx  = r_eval;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_chal_nx  = challenge;
          w_loop_nx  = '0;
          w_rep_nx   = '0;
          w_eval_nx  = '0;
          w_state_nx = S_PRESET;
        end
      end
      S_PRESET: begin
        w_eval_nx  = '0;
        w_state_nx = S_EVAL;
      end
      S_EVAL: begin
        if (r_eval == EVAL_LAST) begin
          w_state_nx = S_STORE;
        end else begin
          w_eval_nx = r_eval + 1'b1;
        end
      end
      S_STORE: begin
        w_eval_nx = '0;
        if (r_loop < LOOP_LAST) begin
          w_loop_nx  = r_loop + 1'b1;
          w_state_nx = S_PRESET;
        end else begin
          w_loop_nx = '0;
          if (r_rep < REP_LAST) begin
            w_rep_nx   = r_rep + 1'b1;
            w_state_nx = S_PRESET;
          end else begin
            w_state_nx = S_DONE;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Loop index only moves when entering PRESET; DONE keeps the last one
  always_comb begin
    w_sum    = {1'b0, w_start_idx} + {1'b0, w_loop_nx};
    w_sel_nx = r_sel;
    if (w_state_nx == S_PRESET) begin
      if (w_sum >= NL_W) begin
        w_sel_nx = SELW'(w_sum - NL_W);
      end else begin
        w_sel_nx = SELW'(w_sum);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_chal  <= '0;
      r_loop  <= '0;
      r_rep   <= '0;
      r_eval  <= '0;
      r_sel   <= '0;
      r_done  <= 1'b0;
      r_rst   <= 1'b0;
      r_en    <= 1'b0;
      r_st    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_chal  <= w_chal_nx;
      r_loop  <= w_loop_nx;
      r_rep   <= w_rep_nx;
      r_eval  <= w_eval_nx;
      r_sel   <= w_sel_nx;
      r_done  <= (w_state_nx == S_DONE);
      r_rst   <= (w_state_nx == S_PRESET);
      r_en    <= (w_state_nx == S_EVAL);
      r_st    <= (w_state_nx == S_STORE);
    end
  end

  assign done               = r_done;
  assign reset_puf          = r_rst;
  assign enable_puf         = r_en;
  assign store_response_puf = r_st;
  assign select_puf         = r_sel;

endmodule

// File: tb/tb_state_machine.sv
// Bench for state_machine: directed plan plus random soak
// against a cycle-offset arithmetic model.
module tb_state_machine;

  localparam int N  = 4;
  localparam int R  = 2;
  localparam int E  = 8;
  localparam int CB = 4;
  localparam int LP = E + 2;
  localparam int TOTAL = N * R * LP;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CB-1:0] challenge;
  logic          done;
  logic          reset_puf;
  logic [2:0]    select_puf;
  logic          enable_puf;
  logic          store_response_puf;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // model: 0 idle, 1 running, 2 done
  int m_mode = 0;
  int m_k    = 0;
  int m_c    = 0;

  int cnt_rp, cnt_en, cnt_st;

  always #5 clk = ~clk;

  state_machine #(
    .NUM_LOOPS(N),
    .REPETITIONS_BITS(16),
    .REPETITIONS(R),
    .EVAL_TIME_BITS(16),
    .EVAL_TIME(E),
    .CHALLENGE_BITS(CB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .challenge(challenge),
    .done(done),
    .reset_puf(reset_puf),
    .select_puf(select_puf),
    .enable_puf(enable_puf),
    .store_response_puf(store_response_puf)
  );

  task automatic chk(input string tag, input int obs,
                     input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d",
               tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic s,
                            input logic [CB-1:0] c);
    if (r) begin
      m_mode = 0;
    end else if (m_mode != 1) begin
      if (s) begin
        m_mode = 1;
        m_k    = 0;
        m_c    = int'(c) % N;
      end
    end else begin
      m_k++;
      if (m_k == TOTAL) m_mode = 2;
    end
  endtask

  task automatic compare();
    int e_done, e_rp, e_en, e_st, e_sel, ph, p;
    e_done = 0; e_rp = 0; e_en = 0; e_st = 0; e_sel = 0;
    if (m_mode == 1) begin
      p  = m_k / LP;
      ph = m_k % LP;
      e_rp  = (ph == 0) ? 1 : 0;
      e_en  = (ph >= 1 && ph <= E) ? 1 : 0;
      e_st  = (ph == E + 1) ? 1 : 0;
      e_sel = (m_c + p) % N;
    end else if (m_mode == 2) begin
      e_done = 1;
      e_sel  = (m_c + N * R - 1) % N;
    end
    chk("done", int'(done), e_done);
    chk("reset_puf", int'(reset_puf), e_rp);
    chk("enable_puf", int'(enable_puf), e_en);
    chk("store", int'(store_response_puf), e_st);
    chk("select", int'(select_puf), e_sel);
    chk("onehot0",
        (int'(reset_puf) + int'(enable_puf)
         + int'(store_response_puf)) <= 1 ? 1 : 0, 1);
    cnt_rp += int'(reset_puf);
    cnt_en += int'(enable_puf);
    cnt_st += int'(store_response_puf);
  endtask

  task automatic step(input logic r, input logic s,
                      input logic [CB-1:0] c);
    reset     = r;
    start     = s;
    challenge = c;
    @(posedge clk);
    model_edge(r, s, c);
    #1;
    cyc++;
    compare();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, CB'($urandom));
  endtask

  initial begin
    cnt_rp = 0; cnt_en = 0; cnt_st = 0;

    for (int i = 0; i < 10; i++)
      step(1'b1, 1'(i & 1), CB'($urandom));
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b0, CB'($urandom));

    // basic run, challenge 0
    cnt_rp = 0; cnt_en = 0; cnt_st = 0;
    step(1'b0, 1'b1, 4'd0);
    idle_cycles(TOTAL + 4);
    chk("n_reset", cnt_rp, N * R);
    chk("n_enable", cnt_en, N * R * E);
    chk("n_store", cnt_st, N * R);
    chk("done_end", int'(done), 1);

    // restart from DONE with wrap-around challenge
    step(1'b0, 1'b1, 4'd6);
    chk("rst_after_restart", int'(reset_puf), 1);
    chk("sel_after_restart", int'(select_puf), 2);
    idle_cycles(TOTAL + 2);

    // busy: start and challenge noise while running
    step(1'b0, 1'b1, CB'($urandom));
    while (m_mode == 1)
      step(1'b0, 1'($urandom_range(0, 1)), CB'($urandom));
    idle_cycles(3);

    // reset mid-run, then a fresh full run
    step(1'b0, 1'b1, CB'($urandom));
    idle_cycles(28);
    step(1'b1, 1'b0, CB'($urandom));
    chk("abort_done", int'(done), 0);
    chk("abort_sel", int'(select_puf), 0);
    idle_cycles(2);
    cnt_st = 0;
    step(1'b0, 1'b1, CB'($urandom));
    idle_cycles(TOTAL + 2);
    chk("n_store_after_abort", cnt_st, N * R);

    // random soak
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 199) == 0),
           1'($urandom_range(0, 29) == 0),
           CB'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
